// File: rtl/load_pkg.sv
// load_pkg: entry-phase encoding and legal period bounds shared by the load conditioner.
package load_pkg;
   typedef enum logic [1:0] {NEED_P = 2'd0, NEED_D = 2'd1, RUN = 2'd2} phase_t;
   localparam logic [2:0] PERIOD_MIN = 3'd2;
   localparam logic [2:0] PERIOD_MAX = 3'd6;
endpackage

// File: rtl/load_conditioner_debounce.sv
// debounce: synchronizes a raw active-low button and emits a one-cycle press on an accepted 1->0 change.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [SYNC_STAGES-1:0] sync;
   logic stable;
   logic [CW-1:0] cnt;
   logic flip;
   // press is combinational so the top registers its strobe on the very edge the level flips
   assign flip = (sync[SYNC_STAGES-1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign press = flip && stable;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync <= '1;
         stable <= 1'b1;
         cnt <= '0;
      end else begin
         for (int i = SYNC_STAGES - 1; i > 0; i--) sync[i] <= sync[i-1];
         sync[0] <= key_n;
         if (flip) stable <= ~stable;
         cnt <= (sync[SYNC_STAGES-1] == stable || flip) ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/load_conditioner.sv
// load_conditioner: turns bouncing buttons and switches into validated load strobes for the divider,
// enforcing period-before-duty entry and rejecting illegal values.
module load_conditioner
   import load_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_p_n,
   input  logic       key_d_n,
   input  logic [2:0] sw_in,
   output logic       LOAD_P,
   output logic       LOAD_D,
   output logic [2:0] PAR_LOAD,
   output logic [1:0] phase,
   output logic       reject
);
   logic press_p, press_d, p_ok, d_ok, acc_p, acc_d;
   logic [SYNC_STAGES-1:0][2:0] sw_sync;
   logic [2:0] sw, per_sh, duty_sh;
   phase_t st;
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_p (
      .clk(clk), .reset(reset), .key_n(key_p_n), .press(press_p));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_d (
      .clk(clk), .reset(reset), .key_n(key_d_n), .press(press_d));
   assign sw = sw_sync[SYNC_STAGES-1];
   assign phase = st;
   assign p_ok = sw >= PERIOD_MIN && sw <= PERIOD_MAX && sw >= duty_sh;
   assign d_ok = st != NEED_P && sw <= per_sh;
   assign acc_p = press_p && p_ok;
   // a duty press colliding with a period press is always discarded
   assign acc_d = press_d && !press_p && d_ok;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_sync <= '0;
         st <= NEED_P;
         per_sh <= '0;
         duty_sh <= '0;
         PAR_LOAD <= '0;
         LOAD_P <= 1'b1;
         LOAD_D <= 1'b1;
         reject <= 1'b0;
      end else begin
         for (int i = SYNC_STAGES - 1; i > 0; i--) sw_sync[i] <= sw_sync[i-1];
         sw_sync[0] <= sw_in;
         LOAD_P <= ~acc_p;
         LOAD_D <= ~acc_d;
         reject <= (press_p && !p_ok) || (press_d && (press_p || !d_ok));
         if (acc_p) begin
            PAR_LOAD <= sw;
            per_sh <= sw;
            if (st == NEED_P) st <= NEED_D;
         end else if (acc_d) begin
            PAR_LOAD <= sw;
            duty_sh <= sw;
            if (st == NEED_D) st <= RUN;
         end
      end
   end
endmodule

// File: tb/tb_load_conditioner.sv
// tb_load_conditioner: scenario tasks plus randomized traffic checked against a window-based reference model.
module tb_load_conditioner;
   localparam int D = 4;
   localparam int S = 2;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic key_p_n = 1'b1;
   logic key_d_n = 1'b1;
   logic [2:0] sw_in = 3'd0;
   logic LOAD_P, LOAD_D, reject;
   logic [2:0] PAR_LOAD;
   logic [1:0] phase;
   int n_cmp = 0;
   int n_bad = 0;

   load_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .key_p_n(key_p_n), .key_d_n(key_d_n), .sw_in(sw_in),
      .LOAD_P(LOAD_P), .LOAD_D(LOAD_D), .PAR_LOAD(PAR_LOAD), .phase(phase), .reject(reject));

   always #5 clk = ~clk;

   // A stable level flips once the last D synchronized samples (raw delayed by S) all differ from it.
   typedef struct packed {
      logic [S+D-1:0] hp;
      logic [S+D-1:0] hd;
      logic [S:0][2:0] hs;
      logic lvl_p, lvl_d, lp, ld, rej;
      logic [2:0] par, per, duty;
      logic [1:0] ph;
   } model_t;
   model_t m;

   function automatic model_t step(model_t c, logic kp, logic kd, logic [2:0] swi, logic rst_n);
      model_t n;
      logic fp, fd, ev_p, ev_d;
      logic [2:0] sw;
      n = c;
      if (!rst_n) begin
         n = '0;
         n.hp = '1;
         n.hd = '1;
         n.lvl_p = 1'b1;
         n.lvl_d = 1'b1;
         n.lp = 1'b1;
         n.ld = 1'b1;
         return n;
      end
      n.hp = {c.hp[S+D-2:0], kp};
      n.hd = {c.hd[S+D-2:0], kd};
      n.hs = {c.hs[S-1:0], swi};
      sw = n.hs[S];
      fp = 1'b1;
      fd = 1'b1;
      for (int i = S; i < S + D; i++) begin
         if (n.hp[i] == c.lvl_p) fp = 1'b0;
         if (n.hd[i] == c.lvl_d) fd = 1'b0;
      end
      ev_p = fp && c.lvl_p;
      ev_d = fd && c.lvl_d;
      n.lvl_p = c.lvl_p ^ fp;
      n.lvl_d = c.lvl_d ^ fd;
      n.lp = 1'b1;
      n.ld = 1'b1;
      n.rej = 1'b0;
      if (ev_p) begin
         if (sw >= 2 && sw <= 6 && sw >= c.duty) begin
            n.par = sw;
            n.per = sw;
            n.lp = 1'b0;
            if (c.ph == 2'd0) n.ph = 2'd1;
         end else n.rej = 1'b1;
         if (ev_d) n.rej = 1'b1;
      end else if (ev_d) begin
         if (c.ph != 2'd0 && sw <= c.per) begin
            n.par = sw;
            n.duty = sw;
            n.ld = 1'b0;
            if (c.ph == 2'd1) n.ph = 2'd2;
         end else n.rej = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk) m <= step(m, key_p_n, key_d_n, sw_in, reset);

   // Drives a press (either or both keys), then idles long enough to see any release event.
   task automatic run_press(input bit p, input bit d, input int hold,
                            output int d_lp, output int d_ld, output int d_rej, output int d_both,
                            output int m_lp, output int m_ld, output int m_rej);
      d_lp = 0; d_ld = 0; d_rej = 0; d_both = 0; m_lp = 0; m_ld = 0; m_rej = 0;
      @(negedge clk);
      key_p_n = !p;
      key_d_n = !d;
      for (int c = 0; c < hold + 12; c++) begin
         @(negedge clk);
         if (c == hold - 1) begin
            key_p_n = 1'b1;
            key_d_n = 1'b1;
         end
         d_lp += int'(LOAD_P === 1'b0);
         d_ld += int'(LOAD_D === 1'b0);
         d_rej += int'(reject === 1'b1);
         d_both += int'(LOAD_P === 1'b0 && reject === 1'b1);
         m_lp += int'(!m.lp);
         m_ld += int'(!m.ld);
         m_rej += int'(m.rej);
      end
   endtask

   task automatic test_reset;
      int lows;
      reset = 1'b0;
      key_p_n = 1'b0;
      sw_in = 3'd5;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({LOAD_P, LOAD_D, PAR_LOAD, phase, reject} !== {1'b1, 1'b1, 3'd0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got %b want 11_000_00_0", {LOAD_P, LOAD_D, PAR_LOAD, phase, reject});
         end
      end
      key_p_n = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      lows = 0;
      repeat (12) begin
         @(negedge clk);
         lows += int'(LOAD_P === 1'b0);
      end
      n_cmp++;
      if (lows != 0) begin
         n_bad++;
         $display("FAIL reset_press: got %0d LOAD_P strobes want 0", lows);
      end
   endtask

   task automatic test_clean_entry;
      int at;
      sw_in = 3'd5;
      repeat (3) @(negedge clk);
      key_p_n = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_cmp++;
         if (LOAD_P !== (c == 6 ? 1'b0 : 1'b1)) begin
            n_bad++;
            $display("FAIL clean_p_latency: cycle %0d got LOAD_P=%b want %b", c, LOAD_P, c != 6);
         end
         if (c == 6) begin
            n_cmp++;
            if (PAR_LOAD !== 3'd5) begin
               n_bad++;
               $display("FAIL clean_p_par: got %0d want 5", PAR_LOAD);
            end
         end
      end
      n_cmp++;
      if (phase !== 2'd1) begin
         n_bad++;
         $display("FAIL clean_p_phase: got %0d want 1", phase);
      end
      key_p_n = 1'b1;
      sw_in = 3'd3;
      repeat (10) @(negedge clk);
      key_d_n = 1'b0;
      at = -1;
      for (int c = 1; c <= 20 && at < 0; c++) begin
         @(negedge clk);
         if (LOAD_D === 1'b0) begin
            at = c;
            n_cmp++;
            if (PAR_LOAD !== 3'd3) begin
               n_bad++;
               $display("FAIL clean_d_par: got %0d want 3", PAR_LOAD);
            end
         end
      end
      n_cmp++;
      if (at != 6) begin
         n_bad++;
         $display("FAIL clean_d_latency: got %0d want 6", at);
      end
      @(negedge clk);
      n_cmp++;
      if (phase !== 2'd2 || LOAD_D !== 1'b1) begin
         n_bad++;
         $display("FAIL clean_d_phase: got phase=%0d LOAD_D=%b want 2/1", phase, LOAD_D);
      end
      key_d_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_bounce;
      int lp, rej, mlp;
      lp = 0; rej = 0; mlp = 0;
      sw_in = 3'd6;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 16 + 10 + 12; c++) begin
         key_p_n = (c < 16) ? ((c % 4) == 3) : (c >= 26);
         @(negedge clk);
         lp += int'(LOAD_P === 1'b0);
         rej += int'(reject === 1'b1);
         mlp += int'(!m.lp);
      end
      n_cmp++;
      if (lp != 1 || rej != 0) begin
         n_bad++;
         $display("FAIL bounce_strobes: got lp=%0d rej=%0d want 1/0", lp, rej);
      end
      n_cmp++;
      if (lp != mlp || PAR_LOAD !== m.par) begin
         n_bad++;
         $display("FAIL bounce_model: got lp=%0d par=%0d want lp=%0d par=%0d", lp, PAR_LOAD, mlp, m.par);
      end
   endtask

   task automatic test_illegal;
      int lp, ld, rj, bo, mlp, mld, mrj;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      sw_in = 3'd3;
      run_press(0, 1, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (rj != 1 || ld != 0 || phase !== 2'd0) begin
         n_bad++;
         $display("FAIL illegal_duty_first: got rej=%0d ld=%0d phase=%0d want 1/0/0", rj, ld, phase);
      end
      sw_in = 3'd7;
      run_press(1, 0, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (rj != 1 || lp != 0 || phase !== 2'd0) begin
         n_bad++;
         $display("FAIL illegal_period7: got rej=%0d lp=%0d phase=%0d want 1/0/0", rj, lp, phase);
      end
      sw_in = 3'd4;
      run_press(1, 0, 10, lp, ld, rj, bo, mlp, mld, mrj);
      sw_in = 3'd3;
      run_press(0, 1, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (phase !== 2'd2 || PAR_LOAD !== 3'd3 || ld != 1) begin
         n_bad++;
         $display("FAIL illegal_setup: got phase=%0d par=%0d ld=%0d want 2/3/1", phase, PAR_LOAD, ld);
      end
      sw_in = 3'd2;
      run_press(1, 0, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (rj != 1 || lp != 0 || PAR_LOAD !== 3'd3) begin
         n_bad++;
         $display("FAIL illegal_below_duty: got rej=%0d lp=%0d par=%0d want 1/0/3", rj, lp, PAR_LOAD);
      end
      n_cmp++;
      if (rj != mrj || lp != mlp || ld != mld) begin
         n_bad++;
         $display("FAIL illegal_model: got %0d/%0d/%0d want %0d/%0d/%0d", rj, lp, ld, mrj, mlp, mld);
      end
   endtask

   task automatic test_simultaneous;
      int lp, ld, rj, bo, mlp, mld, mrj;
      sw_in = 3'd4;
      run_press(1, 1, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (lp != 1 || ld != 0 || rj != 1 || bo != 1) begin
         n_bad++;
         $display("FAIL simul_strobes: got lp=%0d ld=%0d rej=%0d same=%0d want 1/0/1/1", lp, ld, rj, bo);
      end
      n_cmp++;
      if (PAR_LOAD !== 3'd4 || phase !== 2'd2) begin
         n_bad++;
         $display("FAIL simul_par: got par=%0d phase=%0d want 4/2", PAR_LOAD, phase);
      end
   endtask

   task automatic test_mid_reset;
      int lows, lp, ld, rj, bo, mlp, mld, mrj;
      sw_in = 3'd5;
      repeat (3) @(negedge clk);
      key_p_n = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      key_p_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      lows = 0;
      repeat (15) begin
         @(negedge clk);
         lows += int'(LOAD_P === 1'b0);
      end
      n_cmp++;
      if (lows != 0 || phase !== 2'd0 || PAR_LOAD !== 3'd0) begin
         n_bad++;
         $display("FAIL midreset_quiet: got lp=%0d phase=%0d par=%0d want 0/0/0", lows, phase, PAR_LOAD);
      end
      run_press(1, 0, 10, lp, ld, rj, bo, mlp, mld, mrj);
      n_cmp++;
      if (lp != 1 || phase !== 2'd1 || PAR_LOAD !== 3'd5) begin
         n_bad++;
         $display("FAIL midreset_repress: got lp=%0d phase=%0d par=%0d want 1/1/5", lp, phase, PAR_LOAD);
      end
   endtask

   task automatic test_random;
      int tp, td, bad;
      bad = 0;
      tp = 1;
      td = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({LOAD_P, LOAD_D, PAR_LOAD, phase, reject} !== {m.lp, m.ld, m.par, m.ph, m.rej}) begin
            n_bad++;
            if (bad++ < 10)
               $display("FAIL random_cycle%0d: got %b want %b", c, {LOAD_P, LOAD_D, PAR_LOAD, phase, reject},
                        {m.lp, m.ld, m.par, m.ph, m.rej});
         end
         reset = ($urandom_range(0, 799) != 0);
         if (--tp == 0) begin
            key_p_n = ~key_p_n;
            tp = $urandom_range(1, 10);
         end
         if (--td == 0) begin
            key_d_n = ~key_d_n;
            td = $urandom_range(1, 10);
         end
         if ($urandom_range(0, 5) == 0) sw_in = 3'($urandom_range(0, 7));
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_entry();
      test_bounce();
      test_illegal();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/load_conditioner.md
# load_conditioner

Front-end stage that sits directly upstream of the adjustable frequency divider. It turns the raw, bouncing push-buttons and slide switches into clean control for the divider:
- one-cycle active-low `LOAD_P` / `LOAD_D` strobes;
- a stable 3-bit `PAR_LOAD` value.

It enforces the entry workflow (period first, then duty) and drops illegal values before they reach the divider.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- `SYNC_STAGES`, default 2: synchronizer flops per raw input.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-low reset.
- `key_p_n`  in  1  raw period button, low = pressed, asynchronous.
- `key_d_n`  in  1  raw duty button, low = pressed, asynchronous.
- `sw_in`  in  3  raw value switches, asynchronous.
- `LOAD_P`  out  1  period load strobe, active low, one cycle.
- `LOAD_D`  out  1  duty load strobe, active low, one cycle.
- `PAR_LOAD`  out  3  value presented with strobes; held between accepted presses.
- `phase`  out  2  entry phase: 0 NEED_P, 1 NEED_D, 2 RUN.
- `reject`  out  1  one-cycle high pulse when a press is refused.

## Operation
- **Synchronizers.**
  - Every raw input passes through `SYNC_STAGES` flops.
  - Button synchronizers reset to 1 (released). Switch synchronizers reset to 0.
- **Debounce, per button.**
  - Keep a stable level and a counter.
  - The counter increments while the synced level ≠ the stable level. It clears to 0 on any cycle where they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
- **Press event.** A stable 1→0 transition produces one press event. Release (0→1) produces no event. A held button produces exactly one event.
- **Shadows.** `per_sh` and `duty_sh` (3 bits each, reset 0) mirror what the divider holds.
- **Period event.**
  - Valid iff 2 ≤ sw ≤ 6 and sw ≥ `duty_sh`. The period is always accepted in phase terms.
  - If valid: `PAR_LOAD` ← synced sw, `per_sh` ← sw, `LOAD_P` low for the next cycle.
  - Else: `reject` pulses and all state is unchanged.
- **Duty event.**
  - Valid iff phase ≠ NEED_P and sw ≤ `per_sh`.
  - If valid: `PAR_LOAD` ← sw, `duty_sh` ← sw, `LOAD_D` low for the next cycle.
  - Else: `reject` pulses.
- **Phase FSM.**
  - NEED_P → NEED_D on an accepted period.
  - NEED_D → RUN on an accepted duty. An accepted period in NEED_D stays in NEED_D.
  - RUN: both buttons are accepted and the phase stays RUN.
  - There is no path back to NEED_P except reset.
- **Simultaneous events in one cycle.**
  - The period event is processed.
  - The duty event is discarded and `reject` pulses, even if the period is itself rejected.
  - `LOAD_P` and `LOAD_D` are never low in the same cycle.
- **Width rules.** All comparisons are unsigned 3-bit. Values 0, 1 and 7 are never valid periods. A duty of 0 is valid.

## Timing
- **Reset values:** `LOAD_P` = 1, `LOAD_D` = 1, `PAR_LOAD` = 0, `phase` = NEED_P, `reject` = 0. Shadows, counters and stable levels are cleared or released.
- **Mid-operation reset:** applied on the next clock edge. It discards any partial debounce count and any pending strobe.
- **Latency:**
  - If a key is sampled low at edge k and stays low, the press event is internal at edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`−1.
  - The strobe and `reject` are registered and visible for the one cycle after that edge.
- **Data/strobe alignment:** `PAR_LOAD` updates on the same edge that drives the strobe low. It is stable for the whole strobe cycle and afterwards.
- **Switch sampling:** switches are sampled synced but not debounced, in the event cycle.
- **Bounce:** a glitch shorter than `DEBOUNCE_CYCLES` produces no event.

## Structure
- **Package `load_pkg`:** phase enum (NEED_P, NEED_D, RUN), `PERIOD_MIN` = 2, `PERIOD_MAX` = 6.
- **Sub-module `debounce`:**
  - Contains the synchronizer, counter and stable level.
  - Outputs a one-cycle `press` pulse.
  - Parameterised by `DEBOUNCE_CYCLES` and `SYNC_STAGES`; instantiated twice.
- **Top level:** the phase FSM, validation, shadows and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `SYNC_STAGES` = 2.
1. **Reset.** Hold `reset` = 0 for 3 cycles → all outputs at reset values. A press during reset yields no strobe.
2. **Clean entry.** Set sw = 5 and press P, then set sw = 3 and press D.
   - P: `LOAD_P` is low for exactly 1 cycle, 6 cycles after the key falls, with `PAR_LOAD` = 5; `phase` = NEED_D.
   - D: `LOAD_D` low with `PAR_LOAD` = 3; `phase` = RUN.
3. **Bounce.** Toggle `key_p_n` low for 3 cycles, high for 1, repeatedly; then hold low for 10 cycles → exactly one `LOAD_P` strobe, and no event on release.
4. **Illegal values.**
   - From reset, sw = 3 with D pressed → `reject` = 1, `phase` stays NEED_P.
   - sw = 7 with P pressed → `reject`, no strobe.
   - In RUN with period 4 and duty 3, P pressed with sw = 2 → `reject`, `PAR_LOAD` stays 3.
5. **Simultaneous presses.** In RUN, sw = 4, both keys fall on the same cycle → only `LOAD_P` strobes, `PAR_LOAD` = 4, and `reject` pulses in the same cycle.
6. **Mid-operation reset.** Assert `reset` while a debounce count is at 3 → no strobe afterwards; the key must be released and re-pressed for a full count to produce one.
